u109_cpu_cycle_terminator: RTL and testbench



---
 rtl/u109_pkg.sv | 17 +
 rtl/u109_toggle_sync.sv | 33 +++
 rtl/u109_cpu_cycle_terminator.sv | 172 +++++++++++++++++
 tb/tb_u109_cpu_cycle_terminator.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/u109_pkg.sv
// Shared definitions for the u109 CPU cycle terminator.
//   state_t          : terminator FSM states
//   BEATS_LAST       : index of the final beat of a line burst
//   TIMEOUT_CLKS_DEF : default acknowledge timeout in CLK40 clocks
package u109_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    TERM = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam logic [1:0] BEATS_LAST       = 2'b11;
  localparam int         TIMEOUT_CLKS_DEF = 255;

endpackage

// File: rtl/u109_toggle_sync.sv
// Brings a CLK33-domain toggle into CLK40 and turns each change into a
// one-clock pulse.
//   CLK40  : destination clock
//   RESETn : synchronous active-low reset, clears all three flops
//   tgl    : source-domain toggle (asynchronous to CLK40)
//   pulse  : high for one clock per toggle change
// A change first captured by s0 at edge N shows up on pulse after edge N+1.
module u109_toggle_sync
  import u109_pkg::*;
(
  input  logic CLK40,
  input  logic RESETn,
  input  logic tgl,
  output logic pulse
);

  logic s0, s1, dly;

  always_ff @(posedge CLK40) begin
    if (!RESETn) begin
      s0  <= 1'b0;
      s1  <= 1'b0;
      dly <= 1'b0;
    end else begin
      s0  <= tgl;
      s1  <= s0;
      dly <= s1;
    end
  end

  assign pulse = s1 ^ dly;

endmodule

// File: rtl/u109_cpu_cycle_terminator.sv
// 68040-side termination stage for bridge cycles (CLK40 domain).
// Accepts a decoded transfer start, waits for per-data-phase completion
// toggles from the CLK33 PCI sequencer and answers with TAn per beat, or
// TEAn on a PCI abort (or acknowledge timeout when built in).
//   CLK40, RESETn      : clock, synchronous active-low reset
//   TSn, BRIDGE_ENn    : transfer start and bridge decode, active-low
//   BRIDGE_REG_SPACE   : register-space access, not terminated here
//   BURSTn, RnW        : transfer attributes, sampled with TSn
//   PCI_ACK_TGL        : toggles once per accepted PCI data phase
//   PCI_ABORT_TGL      : toggles on master/target abort
//   TAn, TEAn          : CPU transfer / error acknowledge
//   DATA_OEn           : read-data drive enable onto the CPU bus
//   CYCLE_ACTIVE       : high from accept until termination
//   BEAT_CNT           : current beat index
//   TIMEOUT_PULSE      : one-clock pulse when an acknowledge timeout fires
// Build option: define U109_TEA_TIMEOUT_EN to add the acknowledge timeout
// counter; without it WAIT holds until an acknowledge, abort or reset.
module u109_cpu_cycle_terminator
  import u109_pkg::*;
#(
  parameter int TIMEOUT_CLKS = TIMEOUT_CLKS_DEF,
  parameter int BEATS        = 4
) (
  input  logic       CLK40,
  input  logic       RESETn,
  input  logic       TSn,
  input  logic       BRIDGE_ENn,
  input  logic       BRIDGE_REG_SPACE,
  input  logic       BURSTn,
  input  logic       RnW,
  input  logic       PCI_ACK_TGL,
  input  logic       PCI_ABORT_TGL,
  output logic       TAn,
  output logic       TEAn,
  output logic       DATA_OEn,
  output logic       CYCLE_ACTIVE,
  output logic [1:0] BEAT_CNT,
  output logic       TIMEOUT_PULSE
);

  // BEAT_CNT is two bits and the timeout counter eight bits wide.
  if (BEATS != 4 || TIMEOUT_CLKS < 2 || TIMEOUT_CLKS > 256) begin : g_bad_param
    $error("u109_cpu_cycle_terminator: unsupported BEATS/TIMEOUT_CLKS");
  end

  state_t     state;
  logic [1:0] pending;
  logic       burst;
  logic       read;
  logic       ack_edge;
  logic       abort_edge;
  logic [1:0] pend_inc;
  logic       start;

  u109_toggle_sync u_ack_sync (
    .CLK40  (CLK40),
    .RESETn (RESETn),
    .tgl    (PCI_ACK_TGL),
    .pulse  (ack_edge)
  );

  u109_toggle_sync u_abort_sync (
    .CLK40  (CLK40),
    .RESETn (RESETn),
    .tgl    (PCI_ABORT_TGL),
    .pulse  (abort_edge)
  );

  // Pending acknowledges absorb PCI phases that complete faster than the
  // two-clock TA loop; saturates at 3.
  assign pend_inc = (ack_edge && pending != 2'b11) ? pending + 2'd1 : pending;
  assign start    = !TSn && !BRIDGE_ENn && !BRIDGE_REG_SPACE;

`ifdef U109_TEA_TIMEOUT_EN
  logic [7:0] timeout;
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CLKS - 1);
`else
  assign TIMEOUT_PULSE = 1'b0;
`endif

  always_ff @(posedge CLK40) begin
    if (!RESETn) begin
      state        <= IDLE;
      pending      <= 2'd0;
      burst        <= 1'b0;
      read         <= 1'b0;
      TAn          <= 1'b1;
      TEAn         <= 1'b1;
      DATA_OEn     <= 1'b1;
      CYCLE_ACTIVE <= 1'b0;
      BEAT_CNT     <= 2'd0;
`ifdef U109_TEA_TIMEOUT_EN
      timeout       <= 8'd0;
      TIMEOUT_PULSE <= 1'b0;
`endif
    end else begin
`ifdef U109_TEA_TIMEOUT_EN
      TIMEOUT_PULSE <= 1'b0;
`endif
      case (state)
        IDLE: begin
          // Edges arriving with no cycle in flight are stale; drop them.
          pending <= 2'd0;
          if (start) begin
            burst        <= !BURSTn;
            read         <= RnW;
            BEAT_CNT     <= 2'd0;
            CYCLE_ACTIVE <= 1'b1;
            state        <= WAIT;
`ifdef U109_TEA_TIMEOUT_EN
            timeout      <= 8'd0;
`endif
          end
        end

        WAIT: begin
          if (abort_edge) begin
            // Abort wins even if an acknowledge lands in the same clock.
            TEAn    <= 1'b0;
            pending <= pend_inc;
            state   <= ERR;
          end else if (pending != 2'd0 || ack_edge) begin
            TAn      <= 1'b0;
            DATA_OEn <= ~read;
            // A fresh edge alongside a consumed one leaves the count as is.
            pending  <= ack_edge ? pending : pending - 2'd1;
            state    <= TERM;
`ifdef U109_TEA_TIMEOUT_EN
            timeout  <= 8'd0;
`endif
          end else begin
`ifdef U109_TEA_TIMEOUT_EN
            if (timeout == TIMEOUT_LAST) begin
              TEAn          <= 1'b0;
              TIMEOUT_PULSE <= 1'b1;
              timeout       <= 8'd0;
              state         <= ERR;
            end else begin
              timeout <= timeout + 8'd1;
            end
`endif
          end
        end

        TERM: begin
          TAn      <= 1'b1;
          DATA_OEn <= 1'b1;
          if (burst && BEAT_CNT != BEATS_LAST) begin
            BEAT_CNT <= BEAT_CNT + 2'd1;
            pending  <= pend_inc;
            state    <= WAIT;
          end else begin
            CYCLE_ACTIVE <= 1'b0;
            pending      <= 2'd0;
            state        <= IDLE;
          end
        end

        ERR: begin
          // Remaining beats of an aborted burst are abandoned.
          TEAn         <= 1'b1;
          CYCLE_ACTIVE <= 1'b0;
          pending      <= 2'd0;
          state        <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_u109_cpu_cycle_terminator.sv
`timescale 1ns/100ps
module tb_u109_cpu_cycle_terminator;

  logic       CLK40 = 1'b0;
  logic       RESETn = 1'b0;
  logic       TSn = 1'b1;
  logic       BRIDGE_ENn = 1'b1;
  logic       BRIDGE_REG_SPACE = 1'b0;
  logic       BURSTn = 1'b1;
  logic       RnW = 1'b1;
  logic       PCI_ACK_TGL = 1'b0;
  logic       PCI_ABORT_TGL = 1'b0;
  logic       TAn, TEAn, DATA_OEn, CYCLE_ACTIVE, TIMEOUT_PULSE;
  logic [1:0] BEAT_CNT;

  u109_cpu_cycle_terminator #(.TIMEOUT_CLKS(16), .BEATS(4)) dut (
    .CLK40            (CLK40),
    .RESETn           (RESETn),
    .TSn              (TSn),
    .BRIDGE_ENn       (BRIDGE_ENn),
    .BRIDGE_REG_SPACE (BRIDGE_REG_SPACE),
    .BURSTn           (BURSTn),
    .RnW              (RnW),
    .PCI_ACK_TGL      (PCI_ACK_TGL),
    .PCI_ABORT_TGL    (PCI_ABORT_TGL),
    .TAn              (TAn),
    .TEAn             (TEAn),
    .DATA_OEn         (DATA_OEn),
    .CYCLE_ACTIVE     (CYCLE_ACTIVE),
    .BEAT_CNT         (BEAT_CNT),
    .TIMEOUT_PULSE    (TIMEOUT_PULSE)
  );

  always #12.5 CLK40 = ~CLK40;

  // One entry per expected termination: TEA or TA, beat index, DATA_OEn,
  // TIMEOUT_PULSE, and (for TA, when non-zero) clocks since the previous TA.
  typedef struct {
    bit         tea;
    logic [1:0] beat;
    bit         doe;
    bit         tp;
    int         gap;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int   n_pass = 0;
  int   n_tot  = 0;
  int   cyc    = 0;
  int   last_ta = 0;

  always @(posedge CLK40) cyc <= cyc + 1;

  task automatic chk(string name, int act, int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: every TA/TEA clock pops one expected entry.
  always @(negedge CLK40) begin
    if (RESETn === 1'b1 && (TAn === 1'b0 || TEAn === 1'b0)) begin
      if (TAn === 1'b0 && TEAn === 1'b0) chk("ta_tea_overlap", int'(TAn | TEAn), 1);
      else if (sb.size() == 0) chk("queue_entry_for_term", sb.size(), 1);
      else begin
        me = sb.pop_front();
        chk("term_is_tea", int'(TEAn === 1'b0), int'(me.tea));
        chk("term_beat", int'(BEAT_CNT), int'(me.beat));
        chk("term_data_oen", int'(DATA_OEn), int'(me.doe));
        chk("term_timeout_pulse", int'(TIMEOUT_PULSE), int'(me.tp));
        if (TAn === 1'b0) begin
          if (me.gap != 0) chk("ta_gap", cyc - last_ta, me.gap);
          last_ta = cyc;
        end
      end
    end
  end

  task automatic clk_n(int n);
    repeat (n) @(negedge CLK40);
  endtask

  task automatic push(bit tea, logic [1:0] beat, bit doe, bit tp, int gap);
    exp_t e;
    e.tea = tea; e.beat = beat; e.doe = doe; e.tp = tp; e.gap = gap;
    sb.push_back(e);
  endtask

  task automatic start_cycle(bit burst, bit rd, bit reg_sp);
    @(negedge CLK40);
    TSn = 1'b0; BRIDGE_ENn = 1'b0; BRIDGE_REG_SPACE = reg_sp;
    BURSTn = ~burst; RnW = rd;
    @(negedge CLK40);
    TSn = 1'b1; BRIDGE_ENn = 1'b1; BRIDGE_REG_SPACE = 1'b0; BURSTn = 1'b1;
  endtask

  task automatic drain(string name, int max);
    int n = 0;
    while (sb.size() != 0 && n < max) begin
      @(posedge CLK40);
      n++;
    end
    chk(name, sb.size(), 0);
    if (sb.size() != 0) sb.delete();
    @(negedge CLK40);
    #1;
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_tan"}, int'(TAn), 1);
    chk({tag, "_tean"}, int'(TEAn), 1);
    chk({tag, "_data_oen"}, int'(DATA_OEn), 1);
    chk({tag, "_cycle_active"}, int'(CYCLE_ACTIVE), 0);
    chk({tag, "_beat_cnt"}, int'(BEAT_CNT), 0);
    chk({tag, "_timeout_pulse"}, int'(TIMEOUT_PULSE), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clk_n(2);
    #1 chk_reset_vals("reset");
    @(negedge CLK40) RESETn = 1'b1;
    clk_n(2);

    // Single read; a second TS while active must not relatch burst.
    push(0, 2'd0, 0, 0, 0);
    start_cycle(0, 1, 0);
    #1 chk("single_cycle_active", int'(CYCLE_ACTIVE), 1);
    start_cycle(1, 0, 0);
    #3 PCI_ACK_TGL = ~PCI_ACK_TGL;
    drain("single_read_drain", 20);
    chk("single_done_active", int'(CYCLE_ACTIVE), 0);
    chk("single_done_oen", int'(DATA_OEn), 1);

    // Burst write, acknowledges 200 ns apart.
    for (int i = 0; i < 4; i++) push(0, 2'(i), 1, 0, 0);
    start_cycle(1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      #3 PCI_ACK_TGL = ~PCI_ACK_TGL;
      #197;
      if (i == 2) begin
        chk("burst_mid_active", int'(CYCLE_ACTIVE), 1);
        chk("burst_mid_beat", int'(BEAT_CNT), 3);
      end
    end
    drain("burst_write_drain", 20);
    chk("burst_done_active", int'(CYCLE_ACTIVE), 0);

    // Back-to-back read acknowledges every 30 ns: TA every 2 clocks.
    push(0, 2'd0, 0, 0, 0);
    for (int i = 1; i < 4; i++) push(0, 2'(i), 0, 0, 2);
    start_cycle(1, 1, 0);
    for (int i = 0; i < 4; i++) begin
      #3 PCI_ACK_TGL = ~PCI_ACK_TGL;
      #27;
    end
    drain("b2b_drain", 30);
    clk_n(4);
    chk("b2b_done_active", int'(CYCLE_ACTIVE), 0);

    // Abort after the second beat of a burst.
    push(0, 2'd0, 1, 0, 0);
    push(0, 2'd1, 1, 0, 0);
    push(1, 2'd2, 1, 0, 0);
    start_cycle(1, 0, 0);
    #3 PCI_ACK_TGL = ~PCI_ACK_TGL;
    #200 PCI_ACK_TGL = ~PCI_ACK_TGL;
    #200 PCI_ABORT_TGL = ~PCI_ABORT_TGL;
    drain("abort_drain", 20);
    chk("abort_done_active", int'(CYCLE_ACTIVE), 0);
    clk_n(6);

    // Acknowledge and abort land in the same clock: TEA only.
    push(1, 2'd0, 1, 0, 0);
    start_cycle(1, 1, 0);
    #3;
    PCI_ACK_TGL = ~PCI_ACK_TGL;
    PCI_ABORT_TGL = ~PCI_ABORT_TGL;
    drain("ack_abort_drain", 20);
    clk_n(6);
    chk("ack_abort_done_active", int'(CYCLE_ACTIVE), 0);

`ifdef U109_TEA_TIMEOUT_EN
    // No acknowledges: timeout TEA 16 clocks after WAIT entry.
    push(1, 2'd0, 1, 1, 0);
    start_cycle(0, 1, 0);
    clk_n(15);
    #1 chk("timeout_not_yet", int'(TEAn), 1);
    @(negedge CLK40);
    #1;
    chk("timeout_tean", int'(TEAn), 0);
    chk("timeout_pulse", int'(TIMEOUT_PULSE), 1);
    drain("timeout_drain", 5);
    chk("timeout_done_active", int'(CYCLE_ACTIVE), 0);
    chk("timeout_pulse_clear", int'(TIMEOUT_PULSE), 0);
`else
    // No acknowledges and no timeout: cycle holds until reset.
    start_cycle(0, 1, 0);
    clk_n(40);
    #1;
    chk("hold_active", int'(CYCLE_ACTIVE), 1);
    chk("hold_tean", int'(TEAn), 1);
    chk("hold_timeout_pulse", int'(TIMEOUT_PULSE), 0);
    @(negedge CLK40);
    RESETn = 1'b0; PCI_ACK_TGL = 1'b0; PCI_ABORT_TGL = 1'b0;
    clk_n(3);
    RESETn = 1'b1;
    clk_n(1);
    #1 chk("hold_reset_active", int'(CYCLE_ACTIVE), 0);
`endif

    // Register-space access is not terminated here.
    start_cycle(0, 1, 1);
    clk_n(2);
    #1 chk("regspace_no_cycle", int'(CYCLE_ACTIVE), 0);
    PCI_ACK_TGL = ~PCI_ACK_TGL;
    clk_n(6);

    // Reset mid-burst, with a stale toggle left behind by the reset.
    push(0, 2'd0, 1, 0, 0);
    start_cycle(1, 0, 0);
    #3 PCI_ACK_TGL = ~PCI_ACK_TGL;
    drain("midburst_drain", 20);
    chk("midburst_beat", int'(BEAT_CNT), 1);
    chk("midburst_active", int'(CYCLE_ACTIVE), 1);
    @(negedge CLK40) RESETn = 1'b0;
    @(negedge CLK40);
    #1 chk_reset_vals("midreset");
    PCI_ACK_TGL = 1'b1;
    clk_n(2);
    RESETn = 1'b1;
    clk_n(4);
    start_cycle(0, 1, 0);
    clk_n(10);
    #1;
    chk("stale_still_active", int'(CYCLE_ACTIVE), 1);
    chk("stale_no_ta", int'(TAn), 1);
    push(0, 2'd0, 0, 0, 0);
    PCI_ACK_TGL = ~PCI_ACK_TGL;
    drain("stale_close_drain", 20);
    chk("stale_close_active", int'(CYCLE_ACTIVE), 0);
    clk_n(4);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
